// File: rtl/lc3_dp_pkg.sv
// Shared encodings and the sign-extension helper for the parametrised LC-3 datapath.
// Used by lc3_datapath_gen and lc3_regfile_gen.
package lc3_dp_pkg;

    // sext() results are this wide; callers truncate to WIDTH.
    localparam int unsigned SEXT_W = 64;

    typedef enum logic [1:0] {
        ALUK_ADD  = 2'b00,
        ALUK_AND  = 2'b01,
        ALUK_NOT  = 2'b10,
        ALUK_PASS = 2'b11
    } aluk_t;

    typedef enum logic [1:0] {
        PCMUX_INC   = 2'b00,
        PCMUX_ADDER = 2'b01,
        PCMUX_ADDR2 = 2'b10,
        PCMUX_BUS   = 2'b11
    } pcmux_t;

    typedef enum logic [1:0] {
        ADDR2_OFF11 = 2'b00,
        ADDR2_OFF9  = 2'b01,
        ADDR2_OFF6  = 2'b10,
        ADDR2_ZERO  = 2'b11
    } addr2mux_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Sign-extend the low 'bits' bits of v: park the field at the top, then shift back arithmetically.
    function automatic logic [SEXT_W-1:0] sext(input logic [15:0] v, input int unsigned bits);
        logic signed [SEXT_W-1:0] t;
        t = {v, {(SEXT_W-16){1'b0}}};
        t = t <<< (16 - bits);
        t = t >>> (SEXT_W - bits);
        return t;
    endfunction

endpackage

// File: rtl/lc3_regfile_gen.sv
// General register file: NREG x WIDTH, one synchronous write port, two combinational read ports.
module lc3_regfile_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [WIDTH-1:0]         rdata1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [WIDTH-1:0]         rdata2
);

    logic [WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_datapath_gen.sv
// Parametrised LC-3 datapath with internal gated bus and a req/ack memory handshake FSM.
// Define LC3_DP_BUS_CHECK_EN to enable the sticky multi-driver bus_err flag.
module lc3_datapath_gen
    import lc3_dp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8,
    parameter int unsigned LED_W = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_PC,
    input  logic             LD_IR,
    input  logic             LD_REG,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_LED,
    input  logic             GatePC,
    input  logic             GateMDR,
    input  logic             GateALU,
    input  logic             GateMARMUX,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             ADDR1MUX,
    input  logic             SR1MUX,
    input  logic             SR2MUX,
    input  logic             DRMUX,
    input  logic             MIO_EN,
    input  logic             MEM_START,
    input  logic             MEM_WE,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             MEM_DONE,
    output logic [WIDTH-1:0] BUS_Val,
    output logic [WIDTH-1:0] PC_Val,
    output logic [WIDTH-1:0] IR_Val,
    output logic             BEN,
    output logic [LED_W-1:0] LED,
    output logic             bus_err
);

    localparam int unsigned RW = $clog2(NREG);

    logic [WIDTH-1:0] pc, ir, mar, mdr;
    logic [WIDTH-1:0] bus, adder, addr1, addr2, alu_b, alu, pc_next;
    logic [WIDTH-1:0] sr1_data, sr2_data;
    logic [RW-1:0]    sr1_idx, sr2_idx, dr_idx;
    logic [15:0]      ir16;
    logic             n, z, p, ben;
    logic [LED_W-1:0] led;
    mem_state_t       state, state_next;
    logic             we_lat;

    assign ir16 = ir[15:0];

    assign sr1_idx = SR1MUX ? RW'(ir16[11:9]) : RW'(ir16[8:6]);
    assign sr2_idx = RW'(ir16[2:0]);
    assign dr_idx  = DRMUX ? RW'(ir16[11:9]) : RW'(NREG - 1);

    lc3_regfile_gen #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk    (Clk),
        .rst    (Reset),
        .we     (LD_REG),
        .waddr  (dr_idx),
        .wdata  (bus),
        .raddr1 (sr1_idx),
        .rdata1 (sr1_data),
        .raddr2 (sr2_idx),
        .rdata2 (sr2_data)
    );

    always_comb begin
        addr2 = '0;
        case (addr2mux_t'(ADDR2MUX))
            ADDR2_OFF11: addr2 = WIDTH'(sext(ir16, 11));
            ADDR2_OFF9:  addr2 = WIDTH'(sext(ir16, 9));
            ADDR2_OFF6:  addr2 = WIDTH'(sext(ir16, 6));
            default:     addr2 = '0;
        endcase
        addr1 = ADDR1MUX ? pc : sr1_data;
        adder = addr1 + addr2;
    end

    always_comb begin
        alu_b = SR2MUX ? WIDTH'(sext(ir16, 5)) : sr2_data;
        alu   = sr1_data;
        case (aluk_t'(ALUK))
            ALUK_ADD: alu = sr1_data + alu_b;
            ALUK_AND: alu = sr1_data & alu_b;
            ALUK_NOT: alu = ~sr1_data;
            default:  alu = sr1_data;
        endcase
    end

    always_comb begin
        bus = '0;
        if (GateMARMUX)   bus = adder;
        else if (GateALU) bus = alu;
        else if (GatePC)  bus = pc;
        else if (GateMDR) bus = mdr;
    end

    always_comb begin
        pc_next = pc;
        case (pcmux_t'(PCMUX))
            PCMUX_INC: pc_next = pc + {{(WIDTH-1){1'b0}}, 1'b1};
            PCMUX_BUS: pc_next = bus;
            default:   pc_next = adder;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            we_lat <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && MEM_START) begin
                we_lat <= MEM_WE;
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        MEM_DONE   = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_START) state_next = WAIT;
            end
            WAIT: begin
                mem_req = 1'b1;
                mem_we  = we_lat;
                if (mem_ack) state_next = DONE;
            end
            DONE: begin
                MEM_DONE   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // MAR/MDR are frozen during WAIT so the handshake address/data stay stable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            n   <= 1'b0;
            z   <= 1'b0;
            p   <= 1'b0;
            ben <= 1'b0;
            led <= '0;
        end else begin
            if (LD_PC) pc <= pc_next;
            if (LD_IR) ir <= bus;
            if (LD_MAR && state != WAIT) mar <= bus;
            if (state == WAIT && mem_ack && !we_lat) begin
                mdr <= mem_rdata;
            end else if (LD_MDR && state != WAIT) begin
                mdr <= MIO_EN ? mem_rdata : bus;
            end
            if (LD_CC) begin
                n <= bus[WIDTH-1];
                z <= (bus == '0);
                p <= ~bus[WIDTH-1] & (bus != '0);
            end
            if (LD_BEN) ben <= (ir16[11] & n) | (ir16[10] & z) | (ir16[9] & p);
            if (LD_LED) led <= ir16[LED_W-1:0];
        end
    end

`ifdef LC3_DP_BUS_CHECK_EN
    logic       err;
    logic [2:0] gate_cnt;

    assign gate_cnt = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (gate_cnt > 3'd1) begin
            err <= 1'b1;
        end
    end

    assign bus_err = err;
`else
    assign bus_err = 1'b0;
`endif

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign BUS_Val   = bus;
    assign PC_Val    = pc;
    assign IR_Val    = ir;
    assign BEN       = ben;
    assign LED       = led;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Scoreboard bench for lc3_datapath_gen: a 16-bit/8-register instance plus a 32-bit/16-register instance on shared stimulus.
module tb_lc3_datapath_gen;

    typedef enum int {K_BUS, K_PC, K_IR, K_BEN, K_LED, K_REQ, K_WE, K_ADDR, K_WDATA, K_ERR, K_BBUS} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

`ifdef LC3_DP_BUS_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_PC, LD_IR, LD_REG, LD_CC, LD_BEN, LD_MAR, LD_MDR, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MIO_EN, MEM_START, MEM_WE, mem_ack;
    logic [31:0] rdata;

    logic        a_req, a_we, a_done, a_ben, a_err;
    logic [15:0] a_addr, a_wdata, a_bus, a_pc, a_ir;
    logic [9:0]  a_led;

    logic        b_req, b_we, b_done, b_ben, b_err;
    logic [31:0] b_addr, b_wdata, b_bus, b_pc, b_ir;
    logic [9:0]  b_led;

    exp_t exp_q[$];
    int   done_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cnt = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cnt <= cnt + 1;

    lc3_datapath_gen #(.WIDTH(16), .NREG(8), .LED_W(10)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_REG(LD_REG), .LD_CC(LD_CC),
        .LD_BEN(LD_BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .MIO_EN(MIO_EN),
        .MEM_START(MEM_START), .MEM_WE(MEM_WE),
        .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_rdata(rdata[15:0]), .mem_ack(mem_ack), .MEM_DONE(a_done),
        .BUS_Val(a_bus), .PC_Val(a_pc), .IR_Val(a_ir), .BEN(a_ben), .LED(a_led), .bus_err(a_err)
    );

    lc3_datapath_gen #(.WIDTH(32), .NREG(16), .LED_W(10)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_REG(LD_REG), .LD_CC(LD_CC),
        .LD_BEN(LD_BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX), .MIO_EN(MIO_EN),
        .MEM_START(MEM_START), .MEM_WE(MEM_WE),
        .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_rdata(rdata), .mem_ack(mem_ack), .MEM_DONE(b_done),
        .BUS_Val(b_bus), .PC_Val(b_pc), .IR_Val(b_ir), .BEN(b_ben), .LED(b_led), .bus_err(b_err)
    );

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_BUS:   return {16'h0, a_bus};
            K_PC:    return {16'h0, a_pc};
            K_IR:    return {16'h0, a_ir};
            K_BEN:   return {31'h0, a_ben};
            K_LED:   return {22'h0, a_led};
            K_REQ:   return {31'h0, a_req};
            K_WE:    return {31'h0, a_we};
            K_ADDR:  return {16'h0, a_addr};
            K_WDATA: return {16'h0, a_wdata};
            K_ERR:   return {31'h0, a_err};
            default: return b_bus;
        endcase
    endfunction

    // Monitor: checks MEM_DONE timing whenever it pulses, and drains pending observations each cycle.
    always @(negedge Clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        int          want_cyc;
        if (a_done === 1'b1) begin
            compared = compared + 1;
            if (done_q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL mem_done_unexpected: MEM_DONE=1 at cycle %0d, required no pulse", cnt);
            end else begin
                want_cyc = done_q.pop_front();
                if (cnt != want_cyc) begin
                    mismatched = mismatched + 1;
                    $display("FAIL mem_done_cycle: pulse at cycle %0d, required cycle %0d", cnt, want_cyc);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = observe(e.kind);
            compared = compared + 1;
            if (act !== e.exp) begin
                mismatched = mismatched + 1;
                $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
            end
        end
    end

    task automatic want(input string n, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 20) begin
            @(negedge Clk);
            #1;
            i++;
        end
        if (exp_q.size() > 0) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL drain_timeout: %0d observations pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clr();
        {LD_PC, LD_IR, LD_REG, LD_CC, LD_BEN, LD_MAR, LD_MDR, LD_LED} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
        PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
        {ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MIO_EN, MEM_START, MEM_WE, mem_ack} = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        clr();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        rdata = v; MIO_EN = 1'b1; LD_MDR = 1'b1;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        GateMDR = 1'b1; LD_IR = 1'b1;
        tick();
    endtask

    task automatic load_pc(input logic [31:0] v);
        load_mdr(v);
        GateMDR = 1'b1; PCMUX = 2'b11; LD_PC = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s;
        Reset = 1'b1;
        rdata = '0;
        clr();
        @(posedge Clk);
        #1;
        want("rst_pc", K_PC, 32'h0);       want("rst_ir", K_IR, 32'h0);
        want("rst_ben", K_BEN, 32'h0);     want("rst_led", K_LED, 32'h0);
        want("rst_req", K_REQ, 32'h0);     want("rst_addr", K_ADDR, 32'h0);
        want("rst_wdata", K_WDATA, 32'h0); want("rst_bus_idle", K_BUS, 32'h0);
        want("rst_err", K_ERR, 32'h0);
        drain();
        Reset = 1'b0;
        tick();

        // PC increment wraps
        load_pc(32'hFFFF);
        want("pc_load_bus", K_PC, 32'hFFFF); drain();
        LD_PC = 1'b1; PCMUX = 2'b00; tick();
        want("pc_inc_wrap", K_PC, 32'h0000); drain();

        // Address adder with PC=5 and IR=07FF
        load_pc(32'h5);
        load_ir(32'h07FF);
        want("ir_load", K_IR, 32'h07FF); drain();
        GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00;
        want("adder_off11", K_BUS, 32'h0004); drain();
        PCMUX = 2'b01; LD_PC = 1'b1; tick();
        want("pc_from_adder", K_PC, 32'h0004); drain();
        GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
        want("adder_off9", K_BUS, 32'h0003); drain(); tick();
        GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10;
        want("adder_off6", K_BUS, 32'h0003); drain(); tick();
        GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b11;
        want("adder_zero", K_BUS, 32'h0004); drain(); tick();
        GateMARMUX = 1'b1; ADDR1MUX = 1'b0; SR1MUX = 1'b0; ADDR2MUX = 2'b00;
        want("adder_sr1_base", K_BUS, 32'hFFFF); drain(); tick();

        // R1 = 7FFF, then ADD R1,R1,#1 with LD_CC
        load_ir(32'h0200);
        load_mdr(32'h7FFF);
        GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; tick();
        load_ir(32'h1261);
        GateALU = 1'b1; SR1MUX = 1'b0; SR2MUX = 1'b1; ALUK = 2'b00; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        want("alu_add_imm", K_BUS, 32'h8000); drain(); tick();
        GateALU = 1'b1; ALUK = 2'b11;
        want("reg_r1_readback", K_BUS, 32'h8000); drain(); tick();
        GateALU = 1'b1; ALUK = 2'b10;
        want("alu_not", K_BUS, 32'h7FFF); drain(); tick();
        GateALU = 1'b1; ALUK = 2'b01; SR2MUX = 1'b1;
        want("alu_and_imm", K_BUS, 32'h0000); drain(); tick();
        GateALU = 1'b1; ALUK = 2'b00; SR2MUX = 1'b0;
        want("alu_add_reg_wrap", K_BUS, 32'h0000); drain(); tick();

        // Bus priority and conflict flag
        GatePC = 1'b1; GateALU = 1'b1; ALUK = 2'b11;
        want("prio_alu_over_pc", K_BUS, 32'h8000); drain(); tick();
        want("bus_err_set", K_ERR, {31'h0, ERR_EXP}); drain();
        GateMARMUX = 1'b1; GateALU = 1'b1; GatePC = 1'b1; GateMDR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b10;
        want("prio_marmux_top", K_BUS, 32'hFFE5); drain(); tick();
        GatePC = 1'b1; GateMDR = 1'b1;
        want("prio_pc_over_mdr", K_BUS, 32'h0004); drain(); tick();
        tick();
        want("bus_err_sticky", K_ERR, {31'h0, ERR_EXP}); drain();

        // BEN from N (set by the 8000 result)
        load_ir(32'h0800);
        LD_BEN = 1'b1; tick();
        want("ben_n", K_BEN, 32'h1); drain();
        load_ir(32'h0600);
        LD_BEN = 1'b1; tick();
        want("ben_zp_clear", K_BEN, 32'h0); drain();

        load_ir(32'h03A5);
        LD_LED = 1'b1; tick();
        want("led_load", K_LED, 32'h3A5); drain();

        // Read: MAR=3000, ack in the 4th WAIT cycle
        load_mdr(32'h3000);
        GateMDR = 1'b1; LD_MAR = 1'b1; tick();
        want("mar_load", K_ADDR, 32'h3000); drain();
        MEM_START = 1'b1; MEM_WE = 1'b0;
        s = cnt;
        done_q.push_back(s + 5);
        tick();
        want("rd_req_w1", K_REQ, 32'h1); want("rd_we_w1", K_WE, 32'h0); want("rd_addr_w1", K_ADDR, 32'h3000);
        GatePC = 1'b1; LD_MAR = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b1; rdata = 32'h1234;
        drain(); tick();
        want("rd_addr_w2", K_ADDR, 32'h3000); want("rd_mdr_hold_w2", K_WDATA, 32'h3000); drain(); tick();
        want("rd_req_w3", K_REQ, 32'h1); want("rd_addr_w3", K_ADDR, 32'h3000); drain(); tick();
        mem_ack = 1'b1; rdata = 32'h8001;
        want("rd_req_w4", K_REQ, 32'h1); drain(); tick();
        want("rd_req_done", K_REQ, 32'h0); want("rd_mdr", K_WDATA, 32'h8001); drain(); tick();
        want("rd_req_idle", K_REQ, 32'h0); drain();

        // Write: ack in first WAIT cycle, second MEM_START ignored
        load_mdr(32'hABCD);
        MEM_START = 1'b1; MEM_WE = 1'b1;
        s = cnt;
        done_q.push_back(s + 2);
        tick();
        want("wr_req_w1", K_REQ, 32'h1); want("wr_we_w1", K_WE, 32'h1); want("wr_wdata", K_WDATA, 32'hABCD);
        mem_ack = 1'b1; rdata = 32'h5555; MEM_START = 1'b1; MEM_WE = 1'b0;
        drain(); tick();
        want("wr_req_done", K_REQ, 32'h0); want("wr_mdr_kept", K_WDATA, 32'hABCD); drain(); tick();
        mem_ack = 1'b1;
        want("wr_no_second_req", K_REQ, 32'h0); drain(); tick();
        want("idle_ack_ignored", K_REQ, 32'h0); drain(); tick();

        // Reset mid-WAIT
        MEM_START = 1'b1; MEM_WE = 1'b1; tick();
        want("rst_wait_req_before", K_REQ, 32'h1); drain(); tick();
        Reset = 1'b1;
        want("rst_wait_req_async", K_REQ, 32'h0); want("rst_wait_we_async", K_WE, 32'h0);
        want("rst_wait_pc", K_PC, 32'h0); want("rst_wait_led", K_LED, 32'h0); want("rst_wait_err", K_ERR, 32'h0);
        drain(); tick();
        Reset = 1'b0;
        repeat (3) begin
            tick();
            want("post_rst_idle", K_REQ, 32'h0); drain();
        end

        // Wide build: sext(9'h100) and DRMUX=0 targeting the top register
        load_ir(32'h0100);
        GateMARMUX = 1'b1; ADDR1MUX = 1'b0; SR1MUX = 1'b0; ADDR2MUX = 2'b01;
        want("sext9_w16", K_BUS, 32'h0000FF00); want("sext9_w32", K_BBUS, 32'hFFFFFF00); drain(); tick();
        load_ir(32'h0E00);
        load_mdr(32'h12345678);
        GateMDR = 1'b1; DRMUX = 1'b0; LD_REG = 1'b1; tick();
        GateALU = 1'b1; SR1MUX = 1'b1; ALUK = 2'b11;
        want("dr_default_w16_r7", K_BUS, 32'h00005678); want("dr_default_w32_not_r7", K_BBUS, 32'h0); drain(); tick();
        GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; tick();
        GateALU = 1'b1; SR1MUX = 1'b1; ALUK = 2'b11;
        want("dr_ir_w32_r7", K_BBUS, 32'h12345678); drain(); tick();

        if (done_q.size() != 0) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL mem_done_missing: %0d MEM_DONE pulses not seen, required 0", done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lc3_datapath_gen.md
Name: lc3_datapath_gen

Overview:
Parametrised next-generation LC-3 datapath, with data width and register count as parameters.
- Owns PC, IR, MAR, MDR, register file, NZP/BEN, LED latch and the internal gated bus. The previous generation took BUS as an input; this block builds the bus itself.
- Adds a req/ack memory handshake FSM, so the control FSM can wait on variable-latency memory instead of fixed wait states.
- Sits between the control FSM and the memory/IO subsystem.

Parameters:
WIDTH, 16, datapath/bus width in bits; legal values are 16 and above; IR decode uses IR[15:0]; immediates sign-extend to WIDTH.
NREG, 8, number of general registers; must be a power of 2, from 8 to 32; index width RW = $clog2(NREG); register indices are zero-extended IR fields.
LED_W, 10, LED latch width; legal values are 10 and below; loaded from IR[LED_W-1:0].

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
LD_PC, LD_IR, LD_REG, LD_CC, LD_BEN, LD_MAR, LD_MDR, LD_LED  in  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers
PCMUX, ADDR2MUX, ALUK  in  2 each  PC source, offset select, ALU op
ADDR1MUX, SR1MUX, SR2MUX, DRMUX, MIO_EN  in  1 each  mux selects
MEM_START  in  1  one-cycle pulse that starts a memory access
MEM_WE  in  1  access type, sampled with MEM_START (1 = write)
mem_req  out  1  memory request
mem_we  out  1  write qualifier, valid while mem_req is high
mem_addr  out  WIDTH  equals MAR
mem_wdata  out  WIDTH  equals MDR
mem_rdata  in  WIDTH  read data, valid on a cycle where mem_ack is high
mem_ack  in  1  one-cycle acknowledge
MEM_DONE  out  1  one-cycle pulse when an access completes
BUS_Val, PC_Val, IR_Val  out  WIDTH each  observability
BEN  out  1  branch enable
LED  out  LED_W  LED latch
bus_err  out  1  sticky gate conflict flag (optional feature)

Behaviour:
Reset (asynchronous):
- PC, IR, MAR, MDR, all registers, N/Z/P, BEN, LED clear to 0.
- FSM goes to IDLE; mem_req, mem_we, MEM_DONE and bus_err go to 0 immediately, without waiting for a clock edge.

Bus:
- Without the optional feature, drivers resolve by fixed priority GateMARMUX > GateALU > GatePC > GateMDR. With no gate asserted, the bus is 0.

PC source (PCMUX):
- 00: PC+1 (modulo 2^WIDTH)
- 01 and 10: adder output
- 11: bus

Address adder:
- ADDR1 is PC when ADDR1MUX=1, else SR1.
- ADDR2MUX: 00 = sext(IR[10:0]), 01 = sext(IR[8:0]), 10 = sext(IR[5:0]), 11 = 0.
- Sum wraps modulo 2^WIDTH.

Register selects:
- SR1 index: IR[11:9] when SR1MUX=1, else IR[8:6].
- Destination: IR[11:9] when DRMUX=1, else NREG-1.
- SR2 index: IR[2:0].

ALU:
- Operand B is sext(IR[4:0]) when SR2MUX=1, else SR2.
- ALUK: 00 = A+B, 01 = A&B, 10 = ~A, 11 = pass A.

Register file:
- Write on the rising edge when LD_REG=1.
- Reads are combinational and see the old value in the same cycle.

MDR load source:
- mem_rdata when MIO_EN=1, else the bus.
- The FSM also loads MDR on a read ack, regardless of LD_MDR.

Condition codes:
- Computed from the bus at the LD_CC edge. Exactly one of N/Z/P is set: Z if bus==0, N if bus[WIDTH-1]=1, else P.
- BEN = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), registered on LD_BEN.

Memory FSM:
- IDLE, MEM_START=1: capture MEM_WE; next cycle mem_req=1 and state=WAIT.
- WAIT: hold mem_req, mem_we, mem_addr, mem_wdata stable. On mem_ack=1: drop mem_req; for a read, load MDR<=mem_rdata; go to DONE.
- DONE: MEM_DONE=1 for exactly one cycle, then IDLE.
- A MEM_START received while in WAIT or DONE is ignored; no queueing.
- An ack can arrive in the first WAIT cycle, giving minimum access latency MEM_START→MEM_DONE = 3 cycles.
- mem_ack in IDLE or DONE is ignored.
- LD_MAR/LD_MDR while in WAIT are illegal. The block holds MAR/MDR and ignores the load so the handshake stays stable.

Optional Feature:
LC3_DP_BUS_CHECK_EN:
- When defined: any cycle with two or more Gate* asserted sets bus_err, which stays set until Reset. Bus value follows the same priority order.
- When undefined: bus_err is tied to 0 and there is no checking logic.

Decomposition:
- Package lc3_dp_pkg holds ALUK/PCMUX/ADDR2MUX encodings as enums, the mem_state_t enum {IDLE, WAIT, DONE}, and the sext helper function.
- One sub-module, lc3_regfile_gen (WIDTH, NREG): one write port, two async read ports.
- The memory FSM stays inline.

Test Plan:
- Reset asserted mid-WAIT → mem_req drops in the same cycle; state=IDLE; MEM_DONE never pulses.
- Read: MAR=16'h3000, MEM_START with MEM_WE=0, ack after 4 cycles with rdata=16'h8001 → MDR=16'h8001; MEM_DONE pulse on cycle 6; mem_addr stable throughout.
- Write with ack in the first WAIT cycle → MEM_DONE exactly 3 cycles after MEM_START; a second MEM_START during WAIT is ignored (one request only).
- ADD R1=16'h7FFF + imm5=1, then GateALU with LD_CC → R1=16'h8000; N=1; with IR[11]=1, LD_BEN gives BEN=1.
- PCMUX=00 at PC=16'hFFFF → PC=0 (wrap). ADDR2MUX=00 with IR[10:0]=11'h7FF and PC=5 → adder output=4.
- WIDTH=32, NREG=16 build: DRMUX=0 writes R15; sext(IR[8:0]=9'h100)=32'hFFFFFF00. With the macro defined: GatePC and GateALU together → bus_err=1, sticky.
